// File: rtl/muldiv_seq_unit_if.sv
// Handshake/operand bundle between EX-stage control and the sequential divide unit.
interface muldiv_seq_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            START;
  logic [4:0]      OPCODE;
  logic [XLEN-1:0] DATA1;
  logic [XLEN-1:0] DATA2;
  logic            BUSY;
  logic            DONE;
  logic [XLEN-1:0] RESULT;

  modport master (
    output START, OPCODE, DATA1, DATA2,
    input  BUSY, DONE, RESULT
  );

  modport slave (
    input  START, OPCODE, DATA1, DATA2,
    output BUSY, DONE, RESULT
  );
endinterface

// File: rtl/muldiv_seq_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow skip the
// iteration loop and complete one cycle after the request, without raising BUSY.
module muldiv_seq_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic               CLK,
  input logic               RESET,
  muldiv_seq_unit_if.slave  bus
);
  localparam logic [4:0] OP_DIV  = 5'd14;
  localparam logic [4:0] OP_DIVU = 5'd15;
  localparam logic [4:0] OP_REM  = 5'd16;
  localparam logic [4:0] OP_REMU = 5'd17;
  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   quo_q, quo_d;    // dividend magnitude shifting out, quotient shifting in
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;
`ifdef DIV_FASTPATH_EN
  logic              fast_pend_q, fast_pend_d;
  logic [XLEN-1:0]   fast_res_q, fast_res_d;
`endif

  logic              op_valid, op_signed, op_rem;
  logic [XLEN:0]     shifted, trial;
  logic [XLEN-1:0]   q_fix, r_fix;

  // Next-state, datapath step and result selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    done_d    = 1'b0;
`ifdef DIV_FASTPATH_EN
    fast_pend_d = 1'b0;
    fast_res_d  = fast_res_q;
`endif

    op_valid  = (bus.OPCODE == OP_DIV) || (bus.OPCODE == OP_DIVU) ||
                (bus.OPCODE == OP_REM) || (bus.OPCODE == OP_REMU);
    op_signed = (bus.OPCODE == OP_DIV) || (bus.OPCODE == OP_REM);
    op_rem    = (bus.OPCODE == OP_REM) || (bus.OPCODE == OP_REMU);

    // rem < divisor, so the trial difference never reaches 2^XLEN; bit XLEN is the borrow.
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    q_fix   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    r_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

`ifdef DIV_FASTPATH_EN
    if (fast_pend_q) begin
      result_d = fast_res_q;
      done_d   = 1'b1;
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.START && op_valid) begin
`ifdef DIV_FASTPATH_EN
          if (bus.DATA2 == '0) begin
            fast_pend_d = 1'b1;
            fast_res_d  = op_rem ? bus.DATA1 : AllOnes;
          end else if (op_signed && bus.DATA1 == MinNeg && bus.DATA2 == AllOnes) begin
            fast_pend_d = 1'b1;
            fast_res_d  = op_rem ? '0 : MinNeg;
          end else begin
`else
          begin
`endif
            quo_d     = (op_signed && bus.DATA1[XLEN-1]) ? (~bus.DATA1 + 1'b1) : bus.DATA1;
            dvs_d     = (op_signed && bus.DATA2[XLEN-1]) ? (~bus.DATA2 + 1'b1) : bus.DATA2;
            rem_d     = '0;
            cnt_d     = '0;
            is_rem_d  = op_rem;
            // Divide-by-zero keeps an all-ones quotient regardless of signs.
            neg_quo_d = op_signed && (bus.DATA1[XLEN-1] ^ bus.DATA2[XLEN-1]) &&
                        (bus.DATA2 != '0);
            neg_rem_d = op_signed && bus.DATA1[XLEN-1];
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        if (!trial[XLEN]) begin
          rem_d = trial[XLEN-1:0];
        end else begin
          rem_d = shifted[XLEN-1:0];
        end
        quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        result_d = is_rem_q ? r_fix : q_fix;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
`ifdef DIV_FASTPATH_EN
      fast_pend_q <= 1'b0;
      fast_res_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      done_q    <= done_d;
`ifdef DIV_FASTPATH_EN
      fast_pend_q <= fast_pend_d;
      fast_res_q  <= fast_res_d;
`endif
    end
  end

  assign bus.BUSY   = (state_q != StIdle);
  assign bus.DONE   = done_q;
  assign bus.RESULT = result_q;
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for the sequential divide unit.
module tb_muldiv_seq_unit;
  localparam logic [4:0] OP_DIV  = 5'd14;
  localparam logic [4:0] OP_DIVU = 5'd15;
  localparam logic [4:0] OP_REM  = 5'd16;
  localparam logic [4:0] OP_REMU = 5'd17;
  localparam int NormLat  = 33;
  localparam int NormBusy = 33;
`ifdef DIV_FASTPATH_EN
  localparam int SpecLat  = 1;
  localparam int SpecBusy = 0;
`else
  localparam int SpecLat  = 33;
  localparam int SpecBusy = 33;
`endif

  logic clk;
  logic rst;
  int tests;
  int fails;
  logic [31:0] last_res;

  muldiv_seq_unit_if bus ();

  muldiv_seq_unit dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request at the current time; returns #1 after the accepting edge.
  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.START  = 1'b1;
    bus.OPCODE = op;
    bus.DATA1  = a;
    bus.DATA2  = b;
    @(posedge clk);
    #1;
    bus.START  = 1'b0;
    bus.OPCODE = 5'd0;
    bus.DATA1  = 32'hDEAD_BEEF;
    bus.DATA2  = 32'h0000_0001;
  endtask

  task automatic wait_done(input logic [31:0] hold, output int lat, output int busy_n,
                           output int hold_bad);
    lat = 0;
    busy_n = 0;
    hold_bad = 0;
    while (bus.DONE !== 1'b1 && lat < 100) begin
      if (bus.BUSY === 1'b1) busy_n++;
      if (bus.RESULT !== hold) hold_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic watch(input int n, output int dones, output int busys);
    dones = 0;
    busys = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.DONE === 1'b1) dones++;
      if (bus.BUSY === 1'b1) busys++;
    end
  endtask

  task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                     input int exp_busy, input bit tail);
    int lat, busy_n, hold_bad;
    start_op(op, a, b);
    wait_done(last_res, lat, busy_n, hold_bad);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_n), 32'(exp_busy));
    check({tag, "_hold"}, 32'(hold_bad), 32'd0);
    check({tag, "_res"}, bus.RESULT, exp);
    last_res = exp;
    if (tail) begin
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, {31'd0, bus.DONE}, 32'd0);
      check({tag, "_keep"}, bus.RESULT, exp);
    end
  endtask

  initial begin
    int lat, busy_n, hold_bad, dones, busys;
    tests = 0;
    fails = 0;
    last_res = 32'd0;
    rst = 1'b1;
    bus.START = 1'b0;
    bus.OPCODE = 5'd0;
    bus.DATA1 = 32'd0;
    bus.DATA2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    check("rst_done", {31'd0, bus.DONE}, 32'd0);
    check("rst_res", bus.RESULT, 32'd0);

    run("div_6_3", OP_DIV, 32'd6, 32'd3, 32'd2, NormLat, NormBusy, 1'b1);
    run("rem_6_3", OP_REM, 32'd6, 32'd3, 32'd0, NormLat, NormBusy, 1'b1);
    run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NormLat, NormBusy, 1'b1);
    run("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NormLat, NormBusy, 1'b1);
    run("remu_m7_2", OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1, NormLat, NormBusy, 1'b1);
    run("divu_max_2", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, NormLat, NormBusy, 1'b1);

    run("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SpecLat, SpecBusy, 1'b1);
    run("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, SpecLat, SpecBusy, 1'b1);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SpecLat, SpecBusy, 1'b1);
    run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SpecLat, SpecBusy, 1'b1);

    // Second request at E10 while busy must be dropped.
    start_op(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    bus.START  = 1'b1;
    bus.OPCODE = OP_DIVU;
    bus.DATA1  = 32'd1000;
    bus.DATA2  = 32'd3;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    wait_done(last_res, lat, busy_n, hold_bad);
    check("ign_lat", 32'(lat), 32'd23);
    check("ign_busy", 32'(busy_n), 32'd23);
    check("ign_res", bus.RESULT, 32'd14);
    last_res = 32'd14;
    watch(40, dones, busys);
    check("ign_extra_done", 32'(dones), 32'd0);
    check("ign_extra_busy", 32'(busys), 32'd0);

    // Non-divide opcode is ignored.
    start_op(5'd0, 32'd6, 32'd3);
    check("op0_busy_now", {31'd0, bus.BUSY}, 32'd0);
    watch(40, dones, busys);
    check("op0_done", 32'(dones), 32'd0);
    check("op0_busy", 32'(busys), 32'd0);
    check("op0_res", bus.RESULT, last_res);

    // New request accepted in the DONE cycle.
    run("b2b_first", OP_DIVU, 32'd100, 32'd7, 32'd14, NormLat, NormBusy, 1'b0);
    run("b2b_second", OP_DIVU, 32'd1000, 32'd10, 32'd100, NormLat, NormBusy, 1'b1);

    // Reset at E15 aborts the operation.
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.BUSY}, 32'd0);
    check("abort_done", {31'd0, bus.DONE}, 32'd0);
    check("abort_res", bus.RESULT, 32'd0);
    last_res = 32'd0;
    watch(40, dones, busys);
    check("abort_no_done", 32'(dones), 32'd0);
    run("after_abort", OP_DIVU, 32'd100, 32'd7, 32'd14, NormLat, NormBusy, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
